// File: rtl/exu_pkg.sv
// Shared EXU types for the ALU issue queue: operand/entry layouts and the wakeup helper.
// ALU_OP_WIDTH and LA64_DATA_WIDTH carry the same values as the core-wide constants.vh.
package exu_pkg;

    localparam int ALU_OP_WIDTH    = 14;
    localparam int LA64_DATA_WIDTH = 64;
    localparam int PREG_TAG_W      = 6;

    typedef struct packed {
        logic                       rdy;
        logic [PREG_TAG_W-1:0]      tag;
        logic [LA64_DATA_WIDTH-1:0] val;
    } alu_iq_src_t;

    typedef struct packed {
        logic                    valid;
        logic [ALU_OP_WIDTH-1:0] alu_op;
        logic [PREG_TAG_W-1:0]   dst_tag;
        alu_iq_src_t             src1;
        alu_iq_src_t             src2;
    } alu_iq_entry_t;

    // A pending source captures the broadcast value when its producer tag matches.
    function automatic alu_iq_src_t iq_src_wake(
        input alu_iq_src_t                src,
        input logic                       wb_valid,
        input logic [PREG_TAG_W-1:0]      wb_tag,
        input logic [LA64_DATA_WIDTH-1:0] wb_data
    );
        alu_iq_src_t res;
        res = src;
        if (wb_valid && !src.rdy && (src.tag == wb_tag)) begin
            res.rdy = 1'b1;
            res.val = wb_data;
        end
        return res;
    endfunction

endpackage

// File: rtl/dff.sv
// Shared enabled register with asynchronous active-high reset to zero.
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/exu_iq_picker.sv
// Issue-queue select: eligible vector in, one-hot grant out.
// ALU_IQ_OLDEST_FIRST_EN builds an age matrix (oldest wins); otherwise lowest index wins.
module exu_iq_picker #(
    parameter int DEPTH = 4
) (
`ifdef ALU_IQ_OLDEST_FIRST_EN
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] alloc,
`endif
    input  logic [DEPTH-1:0] eligible,
    output logic [DEPTH-1:0] grant
);

`ifdef ALU_IQ_OLDEST_FIRST_EN
    // older_reg[i][j] = 1 when entry i was allocated before entry j
    logic [DEPTH-1:0] older_reg [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                older_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (alloc[i]) begin
                        older_reg[i][j] <= 1'b0;
                    end else if (alloc[j]) begin
                        older_reg[i][j] <= 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = eligible[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (eligible[j] && older_reg[j][i]) begin
                    grant[i] = 1'b0;
                end
            end
        end
    end
`else
    // Isolate the lowest set bit.
    assign grant = eligible & (~eligible + DEPTH'(1));
`endif

endmodule

// File: rtl/exu_alu_issue_queue.sv
// ALU issue queue: holds dispatched micro-ops, captures wakeups, issues one ready op per cycle.
// Optional macro ALU_IQ_OLDEST_FIRST_EN selects oldest-first picking instead of lowest index.
module exu_alu_issue_queue
    import exu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = PREG_TAG_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [ALU_OP_WIDTH-1:0]    disp_alu_op,
    input  logic [TAG_W-1:0]           disp_dst_tag,
    input  logic                       disp_src1_rdy,
    input  logic                       disp_src2_rdy,
    input  logic [TAG_W-1:0]           disp_src1_tag,
    input  logic [TAG_W-1:0]           disp_src2_tag,
    input  logic [LA64_DATA_WIDTH-1:0] disp_src1_val,
    input  logic [LA64_DATA_WIDTH-1:0] disp_src2_val,
    input  logic                       wb_valid,
    input  logic [TAG_W-1:0]           wb_tag,
    input  logic [LA64_DATA_WIDTH-1:0] wb_data,
    output logic                       iss_valid,
    output logic [ALU_OP_WIDTH-1:0]    iss_alu_op,
    output logic [LA64_DATA_WIDTH-1:0] iss_src1,
    output logic [LA64_DATA_WIDTH-1:0] iss_src2,
    output logic [TAG_W-1:0]           iss_dst_tag,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    alu_iq_entry_t entry_reg  [DEPTH];
    alu_iq_entry_t entry_next [DEPTH];
    logic [CNT_W-1:0] count_reg, count_next;

    logic [DEPTH-1:0] eligible, free_vec, alloc, grant;
    logic             accept, issue, issue_fire;
    alu_iq_src_t      disp_src1, disp_src2;

    logic [ALU_OP_WIDTH-1:0]    sel_op;
    logic [TAG_W-1:0]           sel_dst;
    logic [LA64_DATA_WIDTH-1:0] sel_src1, sel_src2;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_vec
            assign eligible[gi] = entry_reg[gi].valid & entry_reg[gi].src1.rdy & entry_reg[gi].src2.rdy;
            assign free_vec[gi] = ~entry_reg[gi].valid;
        end
    endgenerate

    assign disp_ready = (count_reg != CNT_W'(DEPTH)) & ~flush;
    assign accept     = disp_valid & disp_ready;
    assign alloc      = accept ? (free_vec & (~free_vec + DEPTH'(1))) : '0;
    assign issue      = |grant;
    assign issue_fire = issue & ~flush;
    assign count      = count_reg;

    exu_iq_picker #(
        .DEPTH(DEPTH)
    ) u_picker (
`ifdef ALU_IQ_OLDEST_FIRST_EN
        .clk     (clk),
        .rst     (rst),
        .alloc   (alloc),
`endif
        .eligible(eligible),
        .grant   (grant)
    );

    // Dispatching sources see a same-cycle writeback so no wakeup is missed.
    always_comb begin
        disp_src1 = iq_src_wake('{rdy: disp_src1_rdy, tag: disp_src1_tag, val: disp_src1_val},
                                wb_valid, wb_tag, wb_data);
        disp_src2 = iq_src_wake('{rdy: disp_src2_rdy, tag: disp_src2_tag, val: disp_src2_val},
                                wb_valid, wb_tag, wb_data);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_next[i]      = entry_reg[i];
            entry_next[i].src1 = iq_src_wake(entry_reg[i].src1, wb_valid, wb_tag, wb_data);
            entry_next[i].src2 = iq_src_wake(entry_reg[i].src2, wb_valid, wb_tag, wb_data);
            if (grant[i]) begin
                entry_next[i].valid = 1'b0;
            end
            if (alloc[i]) begin
                entry_next[i].valid   = 1'b1;
                entry_next[i].alu_op  = disp_alu_op;
                entry_next[i].dst_tag = disp_dst_tag;
                entry_next[i].src1    = disp_src1;
                entry_next[i].src2    = disp_src2;
            end
            if (flush) begin
                entry_next[i].valid = 1'b0;
            end
        end
    end

    always_comb begin
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count_reg + CNT_W'(accept) - CNT_W'(issue);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
            count_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= entry_next[i];
            end
            count_reg <= count_next;
        end
    end

    // Grant is one-hot, so a plain scan selects the winning entry.
    always_comb begin
        sel_op   = '0;
        sel_dst  = '0;
        sel_src1 = '0;
        sel_src2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                sel_op   = entry_reg[i].alu_op;
                sel_dst  = entry_reg[i].dst_tag;
                sel_src1 = entry_reg[i].src1.val;
                sel_src2 = entry_reg[i].src2.val;
            end
        end
    end

    dff #(.W(1)) u_iss_valid (
        .clk(clk), .rst(rst), .en(1'b1), .d(issue_fire), .q(iss_valid)
    );

    // The op clears on idle cycles so the ALU result mux yields zero.
    dff #(.W(ALU_OP_WIDTH)) u_iss_op (
        .clk(clk), .rst(rst), .en(1'b1),
        .d(issue_fire ? sel_op : '0), .q(iss_alu_op)
    );

    dff #(.W(LA64_DATA_WIDTH)) u_iss_src1 (
        .clk(clk), .rst(rst), .en(issue_fire), .d(sel_src1), .q(iss_src1)
    );

    dff #(.W(LA64_DATA_WIDTH)) u_iss_src2 (
        .clk(clk), .rst(rst), .en(issue_fire), .d(sel_src2), .q(iss_src2)
    );

    dff #(.W(TAG_W)) u_iss_dst (
        .clk(clk), .rst(rst), .en(issue_fire), .d(sel_dst), .q(iss_dst_tag)
    );

endmodule
